// File: rtl/vga_sync_dither_if.sv
// Raster/colour bundle between the VGA back end (master) and the effect logic (slave).
// The master drives the counters, strobes and pins; the slave supplies run and pixel colour.
interface vga_sync_dither_if #(
    parameter int OUT_BITS = 1,
    parameter int IN_BITS  = OUT_BITS + 6,
    parameter int FRAME_W  = 11
);
    logic                run;
    logic [10:0]         hcount;
    logic [9:0]          vcount;
    logic                display_active;
    logic                line_start;
    logic                frame_start;
    logic [FRAME_W-1:0]  frame;
    logic [IN_BITS-1:0]  pix_r;
    logic [IN_BITS-1:0]  pix_g;
    logic [IN_BITS-1:0]  pix_b;
    logic                hsync;
    logic                vsync;
    logic [OUT_BITS-1:0] red;
    logic [OUT_BITS-1:0] green;
    logic [OUT_BITS-1:0] blue;

    modport master (
        input  run, pix_r, pix_g, pix_b,
        output hcount, vcount, display_active, line_start, frame_start, frame,
        output hsync, vsync, red, green, blue
    );

    modport slave (
        output run, pix_r, pix_g, pix_b,
        input  hcount, vcount, display_active, line_start, frame_start, frame,
        input  hsync, vsync, red, green, blue
    );
endinterface

// File: rtl/vga_sync_dither.sv
// VGA raster engine: H/V/frame counters, sync decode, a PIX_LAT-deep tap delay line
// matching the effect pipeline, and a registered 8x8 ordered-dither output stage.
module vga_sync_dither #(
    parameter int H_DISPLAY = 1220,
    parameter int H_FP      = 31,
    parameter int H_SYNC    = 183,
    parameter int H_BP      = 91,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int OUT_BITS  = 1,
    parameter int IN_BITS   = OUT_BITS + 6,
    parameter int PIX_LAT   = 0,
    parameter int FRAME_W   = 11,
    parameter int TEMPORAL  = 1
) (
    input  logic              clk48,
    input  logic              rst_n,
    vga_sync_dither_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
    localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FP);
    localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_DISPLAY);
    localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FP + V_SYNC);

    localparam logic               SYNC_ON   = (SYNC_POL != 0);
    localparam logic               TEMP_EN   = (TEMPORAL != 0);
    localparam logic [FRAME_W-1:0] FRAME_ONE = 1;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [2:0] h;
        logic [2:0] v;
        logic [1:0] f;
    } tap_t;

    localparam tap_t TAP_BLANK = '0;

    function automatic logic [5:0] bayer(input logic [2:0] h, input logic [2:0] v,
                                         input logic [1:0] f);
        logic [2:0] i;
        logic [2:0] j;
        i = h ^ {2'b00, TEMP_EN & f[0]};
        j = v + {2'b00, TEMP_EN & f[1]};
        return {i[0] ^ j[0], i[0], i[1] ^ j[1], i[1], i[2] ^ j[2], i[2]};
    endfunction

    // Round up when the fraction beats the threshold; clamp instead of wrapping.
    function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] c,
                                                   input logic [5:0] thr);
        logic [OUT_BITS:0] sum;
        sum = {1'b0, c[IN_BITS-1:6]} + {{OUT_BITS{1'b0}}, (c[5:0] > thr)};
        return sum[OUT_BITS] ? {OUT_BITS{1'b1}} : sum[OUT_BITS-1:0];
    endfunction

    logic [10:0]         hcount_q, hcount_d;
    logic [9:0]          vcount_q, vcount_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                h_wrap, v_wrap;
    tap_t                tap_now, tap_out;
    logic [5:0]          thr;
    logic                hsync_q, hsync_d, vsync_q, vsync_d;
    logic [OUT_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    always_comb begin
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        frame_d  = frame_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
            if (v_wrap && vga.run) frame_d = frame_q + FRAME_ONE;
        end
    end

    always_comb begin
        tap_now     = TAP_BLANK;
        tap_now.hs  = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
        tap_now.vs  = (vcount_q >= VS_BEG) && (vcount_q < VS_END);
        tap_now.act = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        tap_now.h   = hcount_q[2:0];
        tap_now.v   = vcount_q[2:0];
        tap_now.f   = frame_q[1:0];
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            frame_q  <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            frame_q  <= frame_d;
        end
    end

    // Raster taps wait here for the effect pipeline to return colour.
    if (PIX_LAT == 0) begin : g_nodly
        assign tap_out = tap_now;
    end else begin : g_dly
        tap_t dly_q [PIX_LAT];
        always_ff @(posedge clk48 or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < PIX_LAT; k++) dly_q[k] <= TAP_BLANK;
            end else begin
                dly_q[0] <= tap_now;
                for (int k = 1; k < PIX_LAT; k++) dly_q[k] <= dly_q[k-1];
            end
        end
        assign tap_out = dly_q[PIX_LAT-1];
    end

    always_comb begin
        thr     = bayer(tap_out.h, tap_out.v, tap_out.f);
        hsync_d = tap_out.hs ? SYNC_ON : ~SYNC_ON;
        vsync_d = tap_out.vs ? SYNC_ON : ~SYNC_ON;
        red_d   = tap_out.act ? dither(vga.pix_r, thr) : '0;
        green_d = tap_out.act ? dither(vga.pix_g, thr) : '0;
        blue_d  = tap_out.act ? dither(vga.pix_b, thr) : '0;
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign vga.hcount         = hcount_q;
    assign vga.vcount         = vcount_q;
    assign vga.frame          = frame_q;
    assign vga.display_active = tap_now.act;
    assign vga.line_start     = (hcount_q == 11'd0);
    assign vga.frame_start    = (hcount_q == 11'd0) && (vcount_q == 10'd0);
    assign vga.hsync          = hsync_q;
    assign vga.vsync          = vsync_q;
    assign vga.red            = red_q;
    assign vga.green          = green_q;
    assign vga.blue           = blue_q;
endmodule

// File: tb/tb_vga_sync_dither.sv
// Bench for vga_sync_dither on a shrunken raster: random colour/run stimulus compared every
// clock against a position-based reference model, plus hand-computed pinned expectations.
module tb_vga_sync_dither;
    localparam int HD = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VD = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HD + HFP + HS + HBP;
    localparam int VT = VD + VFP + VS + VBP;
    localparam int OB = 2, IB = OB + 6, PL = 2, FW = 4, TEMP = 1, SP = 0;

    logic clk48 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk48 = ~clk48;

    vga_sync_dither_if #(.OUT_BITS(OB), .IN_BITS(IB), .FRAME_W(FW)) vif ();

    vga_sync_dither #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .OUT_BITS(OB), .IN_BITS(IB), .PIX_LAT(PL),
        .FRAME_W(FW), .TEMPORAL(TEMP)
    ) dut (
        .clk48(clk48),
        .rst_n(rst_n),
        .vga  (vif)
    );

    int vectors = 0;
    int miscompares = 0;
    int mh, mv, mf, n, last_fs;
    int hh[16], hv[16], hf[16], pr[16], pg[16], pb[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, n);
        end
    endtask

    function automatic int mbayer(input int h, input int v, input int f);
        int i, j, x;
        i = (h % 8) ^ ((TEMP != 0) ? (f & 1) : 0);
        j = (v + ((TEMP != 0) ? ((f >> 1) & 1) : 0)) % 8;
        x = i ^ j;
        return (x & 1) * 32 + (i & 1) * 16 + ((x >> 1) & 1) * 8 + ((i >> 1) & 1) * 4
             + ((x >> 2) & 1) * 2 + ((i >> 2) & 1);
    endfunction

    function automatic int mdither(input int c, input int thr);
        int q;
        q = c / 64 + (((c % 64) > thr) ? 1 : 0);
        if (q > (1 << OB) - 1) q = (1 << OB) - 1;
        return q;
    endfunction

    function automatic int rpix(input int mode);
        case (mode)
            1:       return (1 << IB) - 1;
            2:       return 0;
            3:       return ((1 << OB) - 1) * 64 + int'($urandom_range(0, 63));
            default: return int'($urandom_range(0, (1 << IB) - 1));
        endcase
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mf = 0; n = 0; last_fs = -1;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, " hcount"}, vif.hcount, 0);
        chk({tag, " vcount"}, vif.vcount, 0);
        chk({tag, " frame"},  vif.frame, 0);
        chk({tag, " hsync"},  vif.hsync, 1 - SP);
        chk({tag, " vsync"},  vif.vsync, 1 - SP);
        chk({tag, " red"},    vif.red, 0);
        chk({tag, " green"},  vif.green, 0);
        chk({tag, " blue"},   vif.blue, 0);
    endtask

    // Called at a falling edge: checks the DUT against raster position n, drives the next inputs.
    task automatic step(input logic run_v, input int mode);
        int idx, pi, h, v, f, er, eg, eb, r, g, b;
        bit hs_a, vs_a, act_a;
        chk("hcount", vif.hcount, mh);
        chk("vcount", vif.vcount, mv);
        chk("frame", vif.frame, mf);
        chk("display_active", vif.display_active, (mh < HD) && (mv < VD));
        chk("line_start", vif.line_start, mh == 0);
        chk("frame_start", vif.frame_start, (mh == 0) && (mv == 0));
        hs_a = 0; vs_a = 0; er = 0; eg = 0; eb = 0;
        if (n >= PL + 1) begin
            idx = (n - 1 - PL) % 16;
            pi  = (n - 1) % 16;
            h = hh[idx]; v = hv[idx]; f = hf[idx];
            hs_a  = (h >= HD + HFP) && (h < HD + HFP + HS);
            vs_a  = (v >= VD + VFP) && (v < VD + VFP + VS);
            act_a = (h < HD) && (v < VD);
            if (act_a) begin
                er = mdither(pr[pi], mbayer(h, v, f));
                eg = mdither(pg[pi], mbayer(h, v, f));
                eb = mdither(pb[pi], mbayer(h, v, f));
            end
        end
        chk("hsync", vif.hsync, hs_a ? SP : 1 - SP);
        chk("vsync", vif.vsync, vs_a ? SP : 1 - SP);
        chk("red", vif.red, er);
        chk("green", vif.green, eg);
        chk("blue", vif.blue, eb);
        if (vif.frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_start period", n - last_fs, HT * VT);
            last_fs = n;
        end
        r = rpix(mode); g = rpix(mode); b = rpix(mode);
        vif.run = run_v;
        vif.pix_r = IB'(r); vif.pix_g = IB'(g); vif.pix_b = IB'(b);
        hh[n % 16] = mh; hv[n % 16] = mv; hf[n % 16] = mf;
        pr[n % 16] = r;  pg[n % 16] = g;  pb[n % 16] = b;
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
                mv = 0;
                if (run_v) mf = (mf + 1) % (1 << FW);
            end else mv++;
        end else mh++;
        n++;
        @(negedge clk48);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, guard;
        vif.run = 1'b0;
        vif.pix_r = '0; vif.pix_g = '0; vif.pix_b = '0;
        model_reset();

        chk("bayer(0,0,f0)", mbayer(0, 0, 0), 0);
        chk("bayer(1,0,f0)", mbayer(1, 0, 0), 48);
        chk("bayer(7,7,f0)", mbayer(7, 7, 0), 21);
        chk("bayer(0,0,f1)", mbayer(0, 0, 1), 48);
        chk("dither sat", mdither(255, 0), 3);
        chk("dither zero frac", mdither(64, 0), 1);
        cnt = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (32 > mbayer(x, y, 0)) cnt++;
        chk("tile half count", cnt, 32);

        repeat (3) begin
            @(negedge clk48);
            reset_chk("reset");
        end
        rst_n = 1'b1;

        repeat (2 * HT * VT) step(1'b1, int'($urandom_range(0, 3)));
        chk("frame after two frames", vif.frame, 2);

        repeat (HT * VT) begin
            if (mh == PL + 1 && mv < VD) chk("first pixel lit", vif.red, 3);
            if (mh == PL) chk("previous line tail blank", vif.red, 0);
            if (mh == HD + HFP + PL + 1) chk("hsync first low", vif.hsync, 0);
            if (mh == HD + HFP + PL) chk("hsync before start", vif.hsync, 1);
            step(1'b1, 1);
        end
        chk("frame after three frames", vif.frame, 3);

        repeat (HT * VT + HT) step(1'b0, int'($urandom_range(0, 3)));
        chk("frame hold run=0", vif.frame, 3);
        repeat (HT * VT) step(mv == 5, int'($urandom_range(0, 3)));
        chk("frame hold run mid-frame", vif.frame, 3);

        guard = 0;
        while (!(mh == 10 && mv == 5) && guard < 2 * HT * VT) begin
            step(1'b1, 0);
            guard++;
        end
        chk("mid-line hcount", vif.hcount, 10);
        chk("mid-line vcount", vif.vcount, 5);
        #2 rst_n = 1'b0;
        #1 reset_chk("async reset");
        @(negedge clk48);
        reset_chk("reset held");
        model_reset();
        rst_n = 1'b1;
        step(1'b1, 0);
        chk("hcount after release", vif.hcount, 1);
        chk("vcount after release", vif.vcount, 0);
        chk("frame after release", vif.frame, 0);

        guard = 0;
        while (mf != (1 << FW) - 1 && guard < 20 * HT * VT) begin
            step(1'b1, int'($urandom_range(0, 3)));
            guard++;
        end
        chk("frame at max", vif.frame, (1 << FW) - 1);
        guard = 0;
        while (mf != 0 && guard < 2 * HT * VT) begin
            step(1'b1, int'($urandom_range(0, 3)));
            guard++;
        end
        chk("frame wraps to 0", vif.frame, 0);
        repeat (20) step(1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
